// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] OPT_LB  = 3'b000;
  localparam logic [2:0] OPT_LH  = 3'b001;
  localparam logic [2:0] OPT_LW  = 3'b010;
  localparam logic [2:0] OPT_LBU = 3'b100;
  localparam logic [2:0] OPT_LHU = 3'b101;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/arbiter_pick.sv
// Combinational grant selection between two requesters; i_prefer names the
// port that wins when both request in the same cycle.
module arbiter_pick
  import memory_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prefer,
  output logic o_gnt_vld,
  output logic o_gnt_port
);

  always_comb begin
    o_gnt_vld  = i_req0 | i_req1;
    o_gnt_port = PORT0;
    if (i_req0 && i_req1) begin
      o_gnt_port = i_prefer;
    end else if (i_req1) begin
      o_gnt_port = PORT1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one Memory between the core (port 0) and the loader (port 1), one access at a time.
// ARBITER_ROUND_ROBIN_EN: alternate grants on ties; otherwise port 1 always wins a tie.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [2:0]            m0_option,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_write_data,
  output logic [DATA_WIDTH-1:0] m0_read_data,
  output logic                  m0_response,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [2:0]            m1_option,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_write_data,
  output logic [DATA_WIDTH-1:0] m1_read_data,
  output logic                  m1_response,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_option,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  localparam logic [3:0] LAT_C = 4'(MEM_LATENCY);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  r_write;
  logic [2:0]            r_option;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [3:0]            r_cnt;

  logic w_req0;
  logic w_req1;
  logic w_prefer;
  logic w_gnt_vld;
  logic w_gnt_port;
  logic w_grant;
  logic w_last_wait;
  logic w_strobe;

  assign w_req0      = m0_read | m0_write;
  assign w_req1      = m1_read | m1_write;
  assign w_grant     = (r_state == IDLE) && w_gnt_vld;
  assign w_last_wait = (r_cnt == 4'd1);

`ifdef ARBITER_ROUND_ROBIN_EN
  logic r_last;

  // Reset to "port 1 last" so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT1;
    end else if (w_grant) begin
      r_last <= w_gnt_port;
    end
  end

  assign w_prefer = ~r_last;
`else
  assign w_prefer = PORT1;
`endif

  arbiter_pick u_pick (
    .i_req0    (w_req0),
    .i_req1    (w_req1),
    .i_prefer  (w_prefer),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_port(w_gnt_port)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = WAIT;
      WAIT:    if (w_last_wait) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Read+write together on one port is a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= PORT0;
      r_write  <= 1'b0;
      r_option <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_gnt_port;
        if (w_gnt_port == PORT1) begin
          r_write  <= m1_write;
          r_option <= m1_option;
          r_addr   <= m1_address;
          r_wdata  <= m1_write_data;
        end else begin
          r_write  <= m0_write;
          r_option <= m0_option;
          r_addr   <= m0_address;
          r_wdata  <= m0_write_data;
        end
      end
      if (r_state == ACCESS) begin
        r_cnt <= LAT_C;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_last_wait && !r_write) begin
          r_rdata <= mem_read_data;
        end
      end
    end
  end

  assign w_strobe       = (r_state == ACCESS) || (r_state == WAIT);
  assign mem_read       = w_strobe && !r_write;
  assign mem_write      = w_strobe && r_write;
  assign mem_option     = r_option;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;

  assign m0_read_data = r_rdata;
  assign m1_read_data = r_rdata;
  assign m0_response  = (r_state == RESP) && (r_owner == PORT0);
  assign m1_response  = (r_state == RESP) && (r_owner == PORT1);
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized scoreboard bench for memory_arbiter with a word-array reference model.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int LAT = 4;

  logic        clk, rst_n;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [2:0]  m0_option, m1_option;
  logic [31:0] m0_address, m0_write_data, m0_read_data;
  logic [31:0] m1_address, m1_write_data, m1_read_data;
  logic        m0_response, m1_response;
  logic        mem_read, mem_write, busy;
  logic [2:0]  mem_option;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  memory_arbiter #(.MEM_LATENCY(LAT), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_read_data(m0_read_data), .m0_response(m0_response),
    .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_read_data(m1_read_data), .m1_response(m1_response),
    .mem_read(mem_read), .mem_write(mem_write), .mem_option(mem_option),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  opt;
    logic [3:0]  idx;
    logic [31:0] data;
  } req_t;

  typedef struct {
    bit          port;
    bit          wr;
    logic [2:0]  opt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_cyc;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          in_reset;
  exp_t        sbq[$];
  logic [31:0] tbmem[16];
  logic [31:0] ref_mem[16];
  logic [31:0] m_rdreg;
  bit          m_last;
  int          rd_cnt = 0;
  logic [2:0]  opt_tab[5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data only valid once the read strobe has been held LAT cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) tbmem[mem_address[5:2]] <= mem_write_data;
    rd_cnt <= mem_read ? rd_cnt + 1 : 0;
  end
  assign mem_read_data = (mem_read && rd_cnt >= LAT) ? tbmem[mem_address[5:2]] : 32'hBADBAD00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    int k;
    k = $urandom_range(0, 2);
    r.rd = (k != 1);
    r.wr = (k != 0);
    r.opt = opt_tab[$urandom_range(0, 4)];
    r.idx = 4'($urandom_range(0, 15));
    r.data = $urandom;
    return r;
  endfunction

  function automatic bit tie_winner();
`ifdef ARBITER_ROUND_ROBIN_EN
    return ~m_last;
`else
    return 1'b1;
`endif
  endfunction

  function automatic void predict(input bit p, input req_t r, input int exp_cyc);
    exp_t e;
    e.port = p;
    e.wr = r.wr;
    e.opt = r.opt;
    e.addr = {26'd0, r.idx, 2'b00};
    e.wdata = r.data;
    if (r.wr) begin
      ref_mem[r.idx] = r.data;
      e.rdata = m_rdreg;
    end else begin
      e.rdata = ref_mem[r.idx];
      m_rdreg = e.rdata;
    end
    m_last = p;
    e.exp_cyc = exp_cyc;
    sbq.push_back(e);
  endfunction

  task automatic drive(input bit p, input req_t r);
    if (p) begin
      m1_read = r.rd; m1_write = r.wr; m1_option = r.opt;
      m1_address = {26'd0, r.idx, 2'b00}; m1_write_data = r.data;
    end else begin
      m0_read = r.rd; m0_write = r.wr; m0_option = r.opt;
      m0_address = {26'd0, r.idx, 2'b00}; m0_write_data = r.data;
    end
  endtask

  task automatic drop(input bit p);
    if (p) begin m1_read = 1'b0; m1_write = 1'b0; end
    else   begin m0_read = 1'b0; m0_write = 1'b0; end
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy && g < 100);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Requests are raised at a negedge with the DUT idle; the next edge samples them.
  task automatic round(input bit en0, input bit en1, input req_t r0, input req_t r1, input bit early);
    bit w, pend0, pend1;
    int n = 0;
    wait_idle();
    if (en0 && en1) begin
      w = tie_winner();
      predict(w, w ? r1 : r0, cyc + LAT + 2);
      predict(!w, w ? r0 : r1, cyc + 2 * LAT + 5);
    end else if (en0) predict(1'b0, r0, cyc + LAT + 2);
    else if (en1)     predict(1'b1, r1, cyc + LAT + 2);
    if (en0) drive(1'b0, r0);
    if (en1) drive(1'b1, r1);
    pend0 = en0;
    pend1 = en1;
    while ((pend0 || pend1) && n < 3 * (LAT + 4)) begin
      @(negedge clk);
      n++;
      if (early && n == 2) begin drop(1'b0); drop(1'b1); end
      if (m0_response) begin drop(1'b0); pend0 = 1'b0; end
      if (m1_response) begin drop(1'b1); pend1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      chk("round_timeout", {30'd0, pend1, pend0}, 32'd0);
      drop(1'b0); drop(1'b1);
    end
  endtask

  // Both ports keep requesting; a served port re-raises in the following IDLE cycle.
  task automatic contend(input int grants);
    req_t rq[2];
    bit   w, rsp;
    int   g = 1, n = 0;
    wait_idle();
    rq[0] = rand_req();
    rq[1] = rand_req();
    w = tie_winner();
    predict(w, rq[w], cyc + LAT + 2);
    drive(1'b0, rq[0]);
    drive(1'b1, rq[1]);
    while (g <= grants && n < grants * (LAT + 6) + 20) begin
      @(negedge clk);
      n++;
      rsp = w ? m1_response : m0_response;
      if (rsp) begin
        if (g == grants) begin
          drop(1'b0); drop(1'b1);
          g++;
        end else begin
          drop(w);
          @(negedge clk);
          n++;
          rq[w] = rand_req();
          drive(w, rq[w]);
          w = tie_winner();
          predict(w, rq[w], cyc + LAT + 2);
          g++;
        end
      end
    end
    if (g <= grants) begin
      chk("contend_timeout", 32'(g), 32'(grants + 1));
      drop(1'b0); drop(1'b1);
    end
  endtask

  // Scoreboard monitor: strobes, busy and responses are all predicted from the queue head.
  exp_t mon_f;
  bit   mon_have, mon_busy, mon_strobe, mon_resp;
  always @(negedge clk) begin
    if (rst_n && !in_reset) begin
      mon_have = (sbq.size() > 0);
      if (mon_have) mon_f = sbq[0];
      mon_busy   = mon_have && cyc >= mon_f.exp_cyc - LAT - 1 && cyc <= mon_f.exp_cyc;
      mon_strobe = mon_have && cyc >= mon_f.exp_cyc - LAT - 1 && cyc <= mon_f.exp_cyc - 1;
      mon_resp   = mon_have && cyc == mon_f.exp_cyc;
      chk("busy", 32'(busy), 32'(mon_busy));
      chk("mem_read", 32'(mem_read), 32'(mon_strobe && !mon_f.wr));
      chk("mem_write", 32'(mem_write), 32'(mon_strobe && mon_f.wr));
      if (mon_strobe) begin
        chk("mem_address", mem_address, mon_f.addr);
        chk("mem_option", 32'(mem_option), 32'(mon_f.opt));
        chk("mem_write_data", mem_write_data, mon_f.wdata);
      end
      chk("m0_response", 32'(m0_response), 32'(mon_resp && !mon_f.port));
      chk("m1_response", 32'(m1_response), 32'(mon_resp && mon_f.port));
      if (mon_resp) begin
        chk("m0_read_data", m0_read_data, mon_f.rdata);
        chk("m1_read_data", m1_read_data, mon_f.rdata);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r, r1, none;
    logic [31:0] v;
    opt_tab[0] = OPT_LB; opt_tab[1] = OPT_LH; opt_tab[2] = OPT_LW;
    opt_tab[3] = OPT_LBU; opt_tab[4] = OPT_LHU;
    none = '{rd: 1'b0, wr: 1'b0, opt: 3'd0, idx: 4'd0, data: 32'd0};
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      tbmem[i] = v;
      ref_mem[i] = v;
    end
    tbmem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    m0_read = 0; m0_write = 0; m0_option = 0; m0_address = 0; m0_write_data = 0;
    m1_read = 0; m1_write = 0; m1_option = 0; m1_address = 0; m1_write_data = 0;
    in_reset = 1'b1;
    rst_n = 1'b0;
    m_last = 1'b1;
    m_rdreg = 32'd0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_responses", {30'd0, m0_response, m1_response}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_read_data", m0_read_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;

    r = '{rd: 1'b1, wr: 1'b0, opt: OPT_LW, idx: 4'd4, data: 32'd0};
    round(1'b1, 1'b0, r, none, 1'b0);
    r = '{rd: 1'b0, wr: 1'b1, opt: OPT_LW, idx: 4'd8, data: 32'h12345678};
    round(1'b0, 1'b1, none, r, 1'b0);
    r = '{rd: 1'b1, wr: 1'b1, opt: OPT_LH, idx: 4'd2, data: 32'hCAFEF00D};
    round(1'b1, 1'b0, r, none, 1'b0);
    r = '{rd: 1'b1, wr: 1'b0, opt: OPT_LBU, idx: 4'd2, data: 32'd0};
    round(1'b0, 1'b1, none, r, 1'b0);

    contend(6);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 2);
      r = rand_req();
      r1 = rand_req();
      round(k != 1, k != 0, r, r1, (k != 2) && ($urandom_range(0, 3) == 0));
    end

    // Reset during WAIT: strobes drop at once and no response follows.
    wait_idle();
    in_reset = 1'b1;
    r = '{rd: 1'b1, wr: 1'b0, opt: OPT_LW, idx: 4'd5, data: 32'd0};
    drive(1'b0, r);
    repeat (3) @(negedge clk);
    chk("pre_reset_mem_read", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_read_data", m0_read_data, 32'd0);
    drop(1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_reset_responses", {30'd0, m0_response, m1_response}, 32'd0);
    end
    rst_n = 1'b1;
    m_last = 1'b1;
    m_rdreg = 32'd0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_responses", {30'd0, m0_response, m1_response}, 32'd0);
    in_reset = 1'b0;

    r = '{rd: 1'b1, wr: 1'b0, opt: OPT_LW, idx: 4'd5, data: 32'd0};
    round(1'b1, 1'b0, r, none, 1'b0);
    contend(4);

    repeat (LAT + 4) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
